// File: rtl/load_store_unit.sv
// RV32I load/store unit: one word-aligned bus transaction per access with byte-lane steering,
// load sign/zero extension and a request timeout. Define MISALIGNED_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data_r,
  input  logic        data_w,
  input  logic [1:0]  data_size,
  input  logic        unsigned_value,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rd_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             go_s, trap_s, ack_s, timeout_s, misalign_s;
  logic             busy_r, done_r, err_r, bus_req_r, bus_we_r;
  logic [31:0]      rd_data_r, bus_addr_r, bus_wdata_r;
  logic [3:0]       bus_be_r;
  logic [1:0]       size_r, lo_r;
  logic             uns_r;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] v;
    case (size)
      2'b00:   v = {4{wd[7:0]}};
      2'b01:   v = {2{wd[15:0]}};
      default: v = wd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic [1:0] lo,
                                              input logic uns, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   v = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   v = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

`ifdef MISALIGNED_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction
`endif

  // Next-state and completion-cause decode
  always_comb begin
    state_s   = state_r;
    go_s      = 1'b0;
    trap_s    = 1'b0;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
`ifdef MISALIGNED_TRAP_EN
    misalign_s = misaligned(data_size, addr[1:0]);
`else
    misalign_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (start && (data_r || data_w)) begin
          if (misalign_s) begin
            trap_s  = 1'b1;
            state_s = RESP;
          end else begin
            go_s    = 1'b1;
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // An ack in the last allowed cycle takes precedence over the abort
        if (bus_ack) begin
          ack_s   = 1'b1;
          state_s = RESP;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = REQ;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, registered outputs, captured access attributes and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      rd_data_r   <= 32'h0000_0000;
      size_r      <= 2'b00;
      lo_r        <= 2'b00;
      uns_r       <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != IDLE);
      done_r    <= (state_s == RESP);
      bus_req_r <= (state_s == REQ);
      err_r     <= trap_s | timeout_s;

      if (go_s) begin
        cnt_r       <= {CNT_W{1'b0}};
        bus_we_r    <= data_w;
        bus_addr_r  <= {addr[31:2], 2'b00};
        bus_be_r    <= lane_be(data_size, addr[1:0]);
        bus_wdata_r <= lane_wdata(data_size, wdata);
        size_r      <= data_size;
        lo_r        <= addr[1:0];
        uns_r       <= unsigned_value;
      end else if (state_r == REQ) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (trap_s || timeout_s) begin
        rd_data_r <= 32'h0000_0000;
      end else if (ack_s && !bus_we_r) begin
        rd_data_r <= extend_load(size_r, lo_r, uns_r, bus_rdata);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rd_data   = rd_data_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_be    = bus_be_r;
  assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, mid-access reset, then random traffic
// checked against a byte-level reference model.
module tb_load_store_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, data_r = 1'b0, data_w = 1'b0, unsigned_value = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0, bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        busy, done, err, bus_req, bus_we;
  logic [31:0] rd_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .data_r(data_r), .data_w(data_w),
    .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rd_data(rd_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic err; logic [31:0] rd; int due; int reqc; } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  int          n_total = 0, n_bad = 0;
  int          ncyc = 0;
  logic [31:0] sb_rd = 32'h0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Monitor: bus phase against expectations, completion against the done queue
  bus_exp_t  cur_bus;
  done_exp_t mon_e;
  logic      bus_valid = 1'b0;
  logic      prev_req = 1'b0;
  int        req_cnt = 0;
  logic [31:0] mon_rd = 32'h0;

  always @(negedge clk) begin
    if (reset) begin
      req_cnt  = 0;
      prev_req = 1'b0;
      mon_rd   = 32'h0;
    end else begin
      if (bus_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            check("unexpected_bus_req", 128'(1), 128'(0));
            bus_valid = 1'b0;
          end else begin
            cur_bus   = bus_q.pop_front();
            bus_valid = 1'b1;
          end
        end
        if (bus_valid) begin
          check("bus_addr", 128'(bus_addr), 128'(cur_bus.addr));
          check("bus_be", 128'(bus_be), 128'(cur_bus.be));
          check("bus_we", 128'(bus_we), 128'(cur_bus.we));
          if (cur_bus.we) check("bus_wdata", 128'(bus_wdata), 128'(cur_bus.wdata));
        end
        check("busy_in_req", 128'(busy), 128'(1));
        req_cnt++;
      end
      prev_req = bus_req;
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 128'(1), 128'(0));
        end else begin
          mon_e = done_q.pop_front();
          check("err", 128'(err), 128'(mon_e.err));
          check("rd_data", 128'(rd_data), 128'(mon_e.rd));
          check("done_cycle", 128'(ncyc), 128'(mon_e.due));
          check("req_cycles", 128'(req_cnt), 128'(mon_e.reqc));
          check("busy_with_done", 128'(busy), 128'(1));
          mon_rd = mon_e.rd;
        end
        req_cnt = 0;
      end else begin
        check("rd_hold", 128'(rd_data), 128'(mon_rd));
      end
    end
  end

  // Issue one access (called in an idle cycle, #1 after the edge); returns in the next idle cycle
  task automatic do_txn(input logic we_i, input logic re_i, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int wait_n);
    int        nb, lo, off, d, nreq;
    logic      trap, tmo;
    bus_exp_t  be_e;
    done_exp_t de;
    logic [31:0] v;
    start = 1'b1; data_w = we_i; data_r = re_i; data_size = size; unsigned_value = uns;
    addr = a; wdata = wd;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    d = ncyc;
    if (!(we_i || re_i)) begin
      @(posedge clk); #1; start = 1'b0; bus_ack = 1'b0;
      @(posedge clk); #1;
      return;
    end
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lo = int'(a[1:0]);
`ifdef MISALIGNED_TRAP_EN
    trap = (size == 2'd3) || ((lo % nb) != 0);
`else
    trap = 1'b0;
`endif
    tmo = (wait_n >= T);
    off = lo - (lo % nb);
    if (!trap) begin
      be_e.addr = a - 32'(lo);
      be_e.be   = 4'(((1 << nb) - 1) << off);
      be_e.we   = we_i;
      for (int i = 0; i < 4; i++) be_e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      bus_q.push_back(be_e);
    end
    if (trap) begin
      de.err = 1'b1; de.rd = 32'h0; de.due = d + 1; de.reqc = 0; sb_rd = 32'h0;
    end else if (tmo) begin
      de.err = 1'b1; de.rd = 32'h0; de.due = d + T + 1; de.reqc = T; sb_rd = 32'h0;
    end else begin
      if (!we_i) begin
        v = 32'h0;
        for (int j = 0; j < nb; j++) v[8*j +: 8] = rdat[8*(off + j) +: 8];
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        sb_rd = v;
      end
      de.err = 1'b0; de.rd = sb_rd; de.due = d + wait_n + 2; de.reqc = wait_n + 1;
    end
    done_q.push_back(de);

    @(posedge clk); #1;
    start = 1'b0; bus_ack = 1'b0;
    if (trap) begin
      @(posedge clk); #1;
      return;
    end
    nreq = tmo ? T : wait_n + 1;
    for (int c = 1; c <= nreq; c++) begin
      if (!tmo && c == wait_n + 1) begin
        bus_ack = 1'b1; bus_rdata = rdat;
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
      start = 1'($urandom_range(0, 1)); data_r = 1'b1; addr = $urandom;
      @(posedge clk); #1;
    end
    bus_ack = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1)); data_r = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic do_reset_mid();
    bus_exp_t b;
    start = 1'b1; data_r = 1'b1; data_w = 1'b0; data_size = 2'd2; unsigned_value = 1'b0;
    addr = 32'h0000_4000; wdata = $urandom;
    b.addr = 32'h0000_4000; b.be = 4'hF; b.we = 1'b0; b.wdata = 32'h0;
    bus_q.push_back(b);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("reset_mid_outputs",
          128'({busy, done, err, bus_req, bus_we, bus_be, rd_data, bus_addr, bus_wdata}), 128'(0));
    @(posedge clk); #1; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_rd = 32'h0;
  endtask

  initial begin
    logic [1:0] sz;
    int         w;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    check("reset_values",
          128'({busy, done, err, bus_req, bus_we, bus_be, rd_data, bus_addr, bus_wdata}), 128'(0));
    @(posedge clk); #1;

    do_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0);
    do_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 32'h1234_F678, 0);
    do_txn(1'b0, 1'b1, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 32'h1234_F678, 1);
    do_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 5);
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h5555_AAAA, T);
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, T - 1);
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 32'h0BAD_C0DE, 1);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 32'h0, 0);
    do_txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_7002, 32'h1122_3344, 32'h0, 2);
    do_txn(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_7000, 32'h0, 32'h89AB_CDEF, 0);
    do_txn(1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_7001, 32'h0, 32'hFEDC_8765, 0);
    do_reset_mid();
    do_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_8003, 32'h0, 32'h80FF_FFFF, 0);

    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 1))
                                       : int'($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, w);
    end

    repeat (4) @(posedge clk);
    #1;
    check("bus_queue_drained", 128'(bus_q.size()), 128'(0));
    check("done_queue_drained", 128'(done_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the RV32I instruction decoder. It consumes the decoder's `data_r`/`data_w`/`data_size`/`unsigned_value` controls, the ALU-computed effective address and the rs2 store value. It runs one word-aligned request/acknowledge transaction on the data bus with byte-lane steering and a timeout, then returns the sign/zero-extended load value for the register write-back mux (`rd_data_sel = 01`).

## Interface
- `TIMEOUT_CYCLES`, 16: maximum number of cycles `bus_req` stays high without `bus_ack` before the access is aborted. Must be ≥ 1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  access request pulse; sampled only in IDLE.
- `data_r`  in  1  load request, from the decoder.
- `data_w`  in  1  store request, from the decoder; has priority if both are high.
- `data_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (see Configuration).
- `unsigned_value`  in  1  1 means zero-extend the load (LBU/LHU).
- `addr`  in  32  effective byte address.
- `wdata`  in  32  store data (rs2).
- `busy`  out  1  high in REQ and RESP.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; flags a misaligned access or timeout.
- `rd_data`  out  32  extended load result; holds until the next load or error completion.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 means write.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  slave acknowledge; sampled only while `bus_req` is high.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.

## Operation
- States:
  - IDLE: start accepted here only.
  - REQ: `bus_req` held high.
  - RESP: `done` high for one cycle, then return to IDLE.
- Acceptance: `start` high with `data_r` or `data_w` high captures all inputs. If neither is high, `start` is ignored.
- IDLE → REQ on accept. IDLE → RESP with `err` on a trapped misalignment; no bus activity occurs.
- REQ → RESP on `bus_ack`, or on timeout with `err`=1.
- Byte enables and store data:
  - Byte: `bus_be = 4'b0001 << addr[1:0]`, `bus_wdata = {4{wdata[7:0]}}`.
  - Half: `bus_be = addr[1] ? 4'b1100 : 4'b0011`, `bus_wdata = {2{wdata[15:0]}}`.
  - Word: `bus_be = 4'b1111`, `bus_wdata = wdata`.
- Loads drive the same `bus_be` pattern with `bus_we`=0.
- Load extraction: select the byte (`addr[1:0]`) or half (`addr[1]`) lane of `bus_rdata` captured on `bus_ack`. Zero-extend if `unsigned_value`=1, else sign-extend. Word loads pass through.
- Stores leave `rd_data` unchanged. Any `err` completion sets `rd_data` to 0.
- Timeout counter:
  - Cleared on entering REQ; increments each REQ cycle without ack.
  - Abort when the counter equals `TIMEOUT_CYCLES-1` and `bus_ack`=0.
  - An ack in that final cycle wins (normal completion).
- Reset mid-operation: next edge forces IDLE with all outputs at reset values. Any pending `bus_ack` is ignored.

## Timing
- Reset values: `busy`, `done`, `err`, `bus_req`, `bus_we` = 0; `rd_data`, `bus_addr`, `bus_wdata` = 0; `bus_be` = 4'b0000.
- `start` at edge 0 → `bus_req`, `bus_addr`, `bus_be`, `bus_we`, `bus_wdata` registered high/valid from cycle 1.
- `bus_ack` in cycle k (k ≥ 1) → `bus_req` low and `done` high in cycle k+1. Minimum latency is 2 cycles.
- Bus outputs are stable for the whole REQ period.
- `rd_data` is valid in the same cycle as `done` and persists afterwards.
- Timeout: `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `done`+`err` in the following cycle.
- Trapped misalignment: `done`+`err` in cycle 1, `bus_req` never asserted.
- `start` during REQ or RESP is ignored; a back-to-back access is accepted the cycle after RESP.

## Configuration
- `MISALIGNED_TRAP_EN` defined:
  - Misaligned accesses (half with `addr[0]`=1; word with `addr[1:0]`≠0) complete with `err`=1 and no bus transaction.
  - `data_size`=11 is treated the same way.
- `MISALIGNED_TRAP_EN` undefined:
  - No misalignment error. Low address bits are masked to natural alignment (half ignores `addr[0]`, word ignores `addr[1:0]`).
  - `data_size`=11 is treated as word.
  - `err` arises only from timeout.

## Test plan
- SB: `addr`=0x1003, `wdata`=0xAABBCCDD, ack in cycle 1 → `bus_addr`=0x1000, `bus_be`=1000, `bus_wdata`=0xDDDDDDDD, `done` in cycle 2, `err`=0.
- LB/LBU: `addr`=0x2001, `bus_rdata`=0x1234F678 → LB `rd_data`=0xFFFFFFF6; LBU `rd_data`=0x000000F6.
- LH: `addr`=0x2002, `bus_rdata`=0x8001_7FFF, ack after 5 wait cycles → `rd_data`=0xFFFF8001, `done` in cycle 7, `bus_be`=1100.
- Timeout with `TIMEOUT_CYCLES`=4, no ack → `bus_req` high in cycles 1–4, `done`+`err` in cycle 5, `rd_data`=0. Repeat with ack in cycle 4 → normal completion.
- LW at `addr`=0x3002:
  - With `MISALIGNED_TRAP_EN`: `done`+`err` in cycle 1, `bus_req` stays 0.
  - Without it: `bus_addr`=0x3000, `bus_be`=1111, normal completion.
- Reset asserted in cycle 2 of a waiting load → cycle 3 all outputs at reset values. A late `bus_ack` produces no `done`. A new `start` is accepted normally.
